// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the MEM pipeline
//               stage and a loader/debug port. It holds the RAM for LAT cycles
//               per access, alternates grants under contention and stalls the
//               pipeline until a MEM-stage access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_ce,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [31:0]   m_wdata,
    output logic [31:0]   m_rdata,
    output logic          m_stall,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [31:0]   l_rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int c_CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(LAT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic c_OWN_M = 1'b0;
    localparam logic c_OWN_L = 1'b1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_owner;
    logic            r_last;
    logic [c_CW-1:0] r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;

    logic            w_grant_m;
    logic            w_grant_l;
    logic            w_in_acc;
    logic            w_resp_m;
    logic            w_resp_l;

    // Next-state and grant decision; under contention the requester that was
    // not served last wins, so back-to-back traffic alternates.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_m   = 1'b0;
        w_grant_l   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (m_ce && (!l_req || (r_last == c_OWN_L))) begin
                    w_grant_m   = 1'b1;
                    w_state_nxt = c_ACC;
                end else if (l_req) begin
                    w_grant_l   = 1'b1;
                    w_state_nxt = c_ACC;
                end
            end
            c_ACC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access context: winner's request is latched on grant, the latency
    // counter runs during ACC and read data is captured on the last ACC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= c_OWN_M;
            r_last  <= c_OWN_L;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant_m) begin
                r_owner <= c_OWN_M;
                r_last  <= c_OWN_M;
                r_cnt   <= c_CNT_INIT;
                r_we    <= m_we;
                r_addr  <= m_addr;
                r_wdata <= m_wdata;
            end else if (w_grant_l) begin
                r_owner <= c_OWN_L;
                r_last  <= c_OWN_L;
                r_cnt   <= c_CNT_INIT;
                r_we    <= l_we;
                r_addr  <= l_addr;
                r_wdata <= l_wdata;
            end else if (r_state == c_ACC) begin
                if (r_cnt == '0) begin
                    r_rdata <= ram_rdata;
                end else begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end
        end
    end

    // Outputs are gated by rst so a mid-access reset drops the RAM strobes
    // and suppresses any response in the reset cycle itself.
    always_comb begin
        w_in_acc  = !rst && (r_state == c_ACC);
        w_resp_m  = !rst && (r_state == c_RESP) && (r_owner == c_OWN_M);
        w_resp_l  = !rst && (r_state == c_RESP) && (r_owner == c_OWN_L);

        ram_ce    = w_in_acc;
        ram_we    = w_in_acc && r_we;
        ram_addr  = w_in_acc ? r_addr  : '0;
        ram_wdata = w_in_acc ? r_wdata : '0;

        l_gnt     = w_in_acc && (r_owner == c_OWN_L);
        l_done    = w_resp_l;
        l_rdata   = w_resp_l ? r_rdata : '0;

        m_stall   = !rst && m_ce && !w_resp_m;
        m_rdata   = w_resp_m ? r_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter (LAT=2) with a
//               behavioural single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_LAT = 2;
    localparam int c_AW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_ce, m_we, l_req, l_we;
    logic [c_AW-1:0] m_addr, l_addr;
    logic [31:0]     m_wdata, l_wdata;
    logic [31:0]     m_rdata, l_rdata;
    logic            m_stall, l_gnt, l_done;
    logic            ram_ce, ram_we;
    logic [c_AW-1:0] ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;

    logic [31:0]     mem [0:255];
    logic            pl_we;
    logic [7:0]      pl_idx;
    logic [31:0]     pl_data;

    int n_chk = 0;
    int n_err = 0;

    dmem_arbiter #(.LAT(c_LAT), .AW(c_AW)) u_dut (
        .clk(clk), .rst(rst),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_stall(m_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: asynchronous read, write on the rising edge.
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (ram_ce && ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = addr[9:2]; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        m_ce = 1'b0; l_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One MEM-stage access; counts stall / RAM strobe cycles and flags bad RAM
    // address or data while the access is on the bus.
    task automatic m_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int stalls,
                            output int wes, output int ces, output int bad);
        @(posedge clk); #1;
        m_ce = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
        rdata = 32'hFFFF_FFFF; stalls = 0; wes = 0; ces = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!m_stall) begin
                rdata = m_rdata;
                break;
            end
            stalls++;
            if (ram_ce) ces++;
            if (ram_we) wes++;
            if (ram_ce && (ram_addr != addr || (we && ram_wdata != wdata))) bad++;
        end
        @(posedge clk); #1;
        m_ce = 1'b0;
    endtask

    // One loader access; counts l_gnt cycles until the l_done pulse.
    task automatic l_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int gnts, output logic done_seen);
        @(posedge clk); #1;
        l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        rdata = 32'hFFFF_FFFF; gnts = 0; done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (l_done) begin
                rdata = l_rdata;
                done_seen = 1'b1;
                break;
            end
            if (l_gnt) gnts++;
        end
        @(posedge clk); #1;
        l_req = 1'b0;
    endtask

    // Expected per-cycle behaviour under sustained contention after reset:
    // IDLE, ACC(M) x2, RESP(M), IDLE, ACC(L) x2, RESP(L), IDLE, ACC(M)
    // bits: {m_stall, l_gnt, l_done, ram_ce}
    logic [3:0]  exp_vec  [0:9];
    logic [31:0] exp_addr [0:9];

    initial begin
        logic [31:0] rd;
        int          st, we_n, ce_n, bad, gn, done_cnt;
        logic        dn;

        exp_vec[0] = 4'b1000; exp_addr[0] = 32'h0;
        exp_vec[1] = 4'b1001; exp_addr[1] = 32'h40;
        exp_vec[2] = 4'b1001; exp_addr[2] = 32'h40;
        exp_vec[3] = 4'b0000; exp_addr[3] = 32'h0;
        exp_vec[4] = 4'b1000; exp_addr[4] = 32'h0;
        exp_vec[5] = 4'b1101; exp_addr[5] = 32'h100;
        exp_vec[6] = 4'b1101; exp_addr[6] = 32'h100;
        exp_vec[7] = 4'b1010; exp_addr[7] = 32'h0;
        exp_vec[8] = 4'b1000; exp_addr[8] = 32'h0;
        exp_vec[9] = 4'b1001; exp_addr[9] = 32'h40;

        rst = 1'b1; m_ce = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        preload(32'h100, 32'h1234_5678);
        preload(32'h44,  32'hA5A5_5A5A);

        // Reset with both requesters active, then sustained contention.
        @(posedge clk); #1;
        m_ce = 1'b1; m_addr = 32'h40; l_req = 1'b1; l_addr = 32'h100;
        repeat (2) begin
            @(negedge clk);
            check("rst_m_stall", {31'd0, m_stall}, 32'd0);
            check("rst_ram_ce",  {31'd0, ram_ce},  32'd0);
            check("rst_l_done",  {31'd0, l_done},  32'd0);
            check("rst_l_gnt",   {31'd0, l_gnt},   32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l_done) done_cnt++;
            check($sformatf("cont%0d_flags", i), {28'd0, m_stall, l_gnt, l_done, ram_ce},
                  {28'd0, exp_vec[i]});
            check($sformatf("cont%0d_addr", i), ram_addr, exp_addr[i]);
        end
        check("cont_l_done_count", done_cnt, 1);

        // Store then load on the MEM port.
        do_reset();
        m_access(1'b1, 32'h40, 32'hDEAD_BEEF, rd, st, we_n, ce_n, bad);
        check("sw_stalls", st, c_LAT + 1);
        check("sw_ram_we_cycles", we_n, c_LAT);
        check("sw_ram_ce_cycles", ce_n, c_LAT);
        check("sw_bus_ok", bad, 0);
        @(negedge clk);
        check("idle_m_rdata_zero", m_rdata, 32'h0);
        check("idle_ram_addr_zero", ram_addr, 32'h0);

        m_access(1'b0, 32'h40, 32'h0, rd, st, we_n, ce_n, bad);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_stalls", st, c_LAT + 1);
        check("lw_ram_we_cycles", we_n, 0);
        check("lw_bus_ok", bad, 0);

        m_access(1'b0, 32'h44, 32'h0, rd, st, we_n, ce_n, bad);
        check("lw2_rdata", rd, 32'hA5A5_5A5A);

        // Loader read of preloaded data, loader write read back by MEM port.
        l_access(1'b0, 32'h100, 32'h0, rd, gn, dn);
        check("l_rd_done", {31'd0, dn}, 32'd1);
        check("l_rd_gnt_cycles", gn, c_LAT);
        check("l_rd_rdata", rd, 32'h1234_5678);
        @(negedge clk);
        check("idle_l_rdata_zero", l_rdata, 32'h0);

        l_access(1'b1, 32'h200, 32'hCAFE_F00D, rd, gn, dn);
        check("l_wr_done", {31'd0, dn}, 32'd1);
        m_access(1'b0, 32'h200, 32'h0, rd, st, we_n, ce_n, bad);
        check("l_wr_readback", rd, 32'hCAFE_F00D);

        // Reset during the first ACC cycle of a loader write.
        do_reset();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h300; l_wdata = 32'h1111_2222;
        @(negedge clk);
        check("abort_idle_gnt", {31'd0, l_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_acc_gnt", {31'd0, l_gnt}, 32'd1);
        check("abort_acc_we", {31'd0, ram_we}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; l_req = 1'b0;
        @(negedge clk);
        check("abort_rst_ram_ce", {31'd0, ram_ce}, 32'd0);
        check("abort_rst_l_done", {31'd0, l_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (l_done || ram_ce || l_gnt) done_cnt++;
        end
        check("abort_quiet_after", done_cnt, 0);
        m_access(1'b0, 32'h40, 32'h0, rd, st, we_n, ce_n, bad);
        check("abort_then_lw_stalls", st, c_LAT + 1);
        check("abort_then_lw_rdata", rd, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
